mul_sequencer: RTL and testbench

- Multi-cycle sequencer for the multiply opcodes of the ALU control encoding: 101 MUL, 110 UMULL, 111 SMULL.
- The single-cycle ALU only covers the add/logic opcodes; this block runs beside it and computes products with a radix-2 shift-add loop (one partial product per clock).
- The core controller starts it with a one-cycle start pulse and stalls on busy until done.
- It returns the low word, the high word and NZCV flags in the same format as the ALU.

---
 rtl/mul_sequencer_if.sv | 26 ++
 rtl/mul_sequencer.sv | 119 +++++++++++
 tb/tb_mul_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mul_sequencer_if.sv
// Handshake and operand/result bundle between the core controller and the multiply sequencer.
// The controller takes the master side and the sequencer takes the slave side.
interface mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] Result2;
    logic [3:0]       ALUFlags;

    modport master (
        output start, flush, ALUControl, a, b,
        input  busy, done, Result, Result2, ALUFlags
    );

    modport slave (
        input  start, flush, ALUControl, a, b,
        output busy, done, Result, Result2, ALUFlags
    );
endinterface

// File: rtl/mul_sequencer.sv
// Radix-2 shift-add multiplier for MUL / UMULL / SMULL, one partial product per clock.
// Signed products are formed from operand magnitudes and negated once at the end.
//
// state | meaning
// IDLE  | waiting for an accepted start
// RUN   | WIDTH shift-add iterations
// FIX   | sign fix-up, result and flag registers loaded
// DONE  | one-cycle done pulse, may accept a back-to-back start
module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    mul_sequencer_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [2:0] OP_SMULL = 3'b111;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         op_q;
    logic               neg_q;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result2_q;
    logic [3:0]         flags_q;

    logic               op_ok;
    logic               accept;
    logic               is_smull;
    logic [WIDTH-1:0]   load_a;
    logic [WIDTH-1:0]   load_b;
    logic [WIDTH:0]     hi_sum;
    logic [2*WIDTH-1:0] prod;

    // Multiply opcodes are 101, 110 and 111.
    assign op_ok    = bus.ALUControl[2] && (bus.ALUControl[1:0] != 2'b00);
    assign accept   = bus.start && op_ok && !bus.flush && (state == IDLE || state == DONE);
    assign is_smull = (bus.ALUControl == OP_SMULL);

    // The most negative value maps onto its unsigned magnitude, so no extra bit is needed.
    assign load_a = (is_smull && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign load_b = (is_smull && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    assign hi_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : '0)};
    assign prod   = neg_q ? -acc : acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (bus.flush) state_nxt = IDLE;
                     else if (cnt == LAST) state_nxt = FIX;
            FIX:     state_nxt = bus.flush ? IDLE : DONE;
            DONE:    state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN) || (state == FIX);
        bus.done = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= '0;
            neg_q     <= 1'b0;
            cnt       <= '0;
            mcand     <= '0;
            acc       <= '0;
            result_q  <= '0;
            result2_q <= '0;
            flags_q   <= '0;
        end else begin
            if (accept) begin
                op_q  <= bus.ALUControl;
                neg_q <= is_smull && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                cnt   <= '0;
                mcand <= load_a;
                acc   <= {{WIDTH{1'b0}}, load_b};
            end else if (state == RUN) begin
                // Multiplier bits retire from the bottom as the product fills in from the top.
                acc <= {hi_sum, acc[WIDTH-1:1]};
                cnt <= cnt + CW'(1);
            end

            if (state == FIX && !bus.flush) begin
                result_q <= prod[WIDTH-1:0];
                if (op_q == OP_MUL) begin
                    result2_q <= '0;
                    flags_q   <= {prod[WIDTH-1], (prod[WIDTH-1:0] == '0), 2'b00};
                end else begin
                    result2_q <= prod[2*WIDTH-1:WIDTH];
                    flags_q   <= {prod[2*WIDTH-1], (prod == '0), 2'b00};
                end
            end
        end
    end

    assign bus.Result   = result_q;
    assign bus.Result2  = result2_q;
    assign bus.ALUFlags = flags_q;
endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: a cycle-level behavioural model compared every
// cycle, directed cases with hand-computed expectations, and a randomized traffic phase.
module tb_mul_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_sequencer_if #(.WIDTH(W)) bus();
    mul_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an op occupies WIDTH+1 busy cycles, then results appear with done.
    int         m_rem   = 0;
    logic       m_done  = 1'b0;
    logic [31:0] m_lo   = '0;
    logic [31:0] m_hi   = '0;
    logic [3:0]  m_flags = '0;
    logic [31:0] p_lo   = '0;
    logic [31:0] p_hi   = '0;
    logic [3:0]  p_flags = '0;

    function automatic void predict(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] lo, output logic [31:0] hi,
                                    output logic [3:0] fl);
        logic [63:0] p;
        longint sx, sy;
        if (op == 3'b101) begin
            lo = x * y;
            hi = '0;
            fl = {lo[31], (lo == 32'd0), 2'b00};
        end else begin
            if (op == 3'b111) begin
                sx = $signed(x);
                sy = $signed(y);
                p  = sx * sy;
            end else begin
                p = {32'd0, x} * {32'd0, y};
            end
            lo = p[31:0];
            hi = p[63:32];
            fl = {p[63], (p == 64'd0), 2'b00};
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem = 0; m_done = 1'b0; m_lo = '0; m_hi = '0; m_flags = '0;
        end else if (m_rem > 0) begin
            m_done = 1'b0;
            if (bus.flush) begin
                m_rem = 0;
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1'b1; m_lo = p_lo; m_hi = p_hi; m_flags = p_flags;
                end
            end
        end else begin
            m_done = 1'b0;
            if (!bus.flush && bus.start && bus.ALUControl >= 3'd5) begin
                m_rem = W + 1;
                predict(bus.ALUControl, bus.a, bus.b, p_lo, p_hi, p_flags);
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 64'(bus.busy), 64'(m_rem > 0));
        check("done", 64'(bus.done), 64'(m_done));
        check("Result", 64'(bus.Result), 64'(m_lo));
        check("Result2", 64'(bus.Result2), 64'(m_hi));
        check("ALUFlags", 64'(bus.ALUFlags), 64'(m_flags));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Pulses start, waits (bounded) for done and checks the latency from the accept edge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          input int poke_at);
        int lat;
        bus.ALUControl = op; bus.a = x; bus.b = y; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy_after_accept", 64'(bus.busy), 64'd1);
        lat = 0;
        while (!bus.done && lat < 40) begin
            if (lat == poke_at) begin
                bus.start = 1'b1; bus.ALUControl = 3'b110;
                bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF0;
            end
            tick();
            bus.start = 1'b0;
            lat++;
        end
        check("latency", 64'(lat), 64'd33);
    endtask

    task automatic expect_out(input string name, input logic [31:0] lo, input logic [31:0] hi,
                              input logic [3:0] fl);
        check({name, "_lo"}, 64'(bus.Result), 64'(lo));
        check({name, "_hi"}, 64'(bus.Result2), 64'(hi));
        check({name, "_flags"}, 64'(bus.ALUFlags), 64'(fl));
        check({name, "_model_lo"}, 64'(m_lo), 64'(lo));
        check({name, "_model_hi"}, 64'(m_hi), 64'(hi));
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int seen;
        bus.start = 1'b0; bus.flush = 1'b0; bus.ALUControl = 3'b000;
        bus.a = '0; bus.b = '0;
        repeat (3) tick();
        expect_out("reset", 32'h0, 32'h0, 4'b0000);
        check("reset_busy", 64'(bus.busy), 64'd0);
        rst_n = 1'b1;
        tick();

        run_op(3'b101, 32'd3, 32'd5, -1);
        expect_out("mul_3x5", 32'h0000_000F, 32'h0, 4'b0000);
        tick();

        run_op(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        expect_out("umull_max", 32'h0000_0001, 32'hFFFF_FFFE, 4'b1000);
        tick();

        run_op(3'b111, 32'hFFFF_FFFE, 32'd3, -1);
        expect_out("smull_m2x3", 32'hFFFF_FFFA, 32'hFFFF_FFFF, 4'b1000);
        tick();

        run_op(3'b111, 32'h8000_0000, 32'h8000_0000, -1);
        expect_out("smull_min", 32'h0, 32'h4000_0000, 4'b0000);
        tick();

        run_op(3'b101, 32'h0001_0000, 32'h0001_0000, -1);
        expect_out("mul_zero", 32'h0, 32'h0, 4'b0100);
        // start in the done cycle: accepted back-to-back
        run_op(3'b101, 32'd7, 32'd6, -1);
        expect_out("mul_b2b", 32'h0000_002A, 32'h0, 4'b0000);
        repeat (2) tick();

        bus.ALUControl = 3'b000; bus.a = 32'd99; bus.b = 32'd99; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("bad_op_busy", 64'(bus.busy), 64'd0);
        expect_out("bad_op_hold", 32'h0000_002A, 32'h0, 4'b0000);
        tick();

        run_op(3'b101, 32'd9, 32'd9, 9);
        expect_out("start_ignored", 32'h0000_0051, 32'h0, 4'b0000);
        repeat (2) tick();

        bus.ALUControl = 3'b110; bus.a = 32'd11; bus.b = 32'd13; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        seen = 0;
        repeat (40) begin
            tick();
            if (bus.done) seen++;
        end
        check("flush_no_done", 64'(seen), 64'd0);
        expect_out("flush_hold", 32'h0000_0051, 32'h0, 4'b0000);

        bus.ALUControl = 3'b111; bus.a = 32'hFFFF_FFF0; bus.b = 32'd5; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (19) tick();
        rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_lo", 64'(bus.Result), 64'd0);
        check("rst_flags", 64'(bus.ALUFlags), 64'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            tick();
            if (bus.done) seen++;
        end
        check("rst_no_done", 64'(seen), 64'd0);
        expect_out("rst_clear", 32'h0, 32'h0, 4'b0000);

        for (int i = 0; i < 4000; i++) begin
            bus.start      = ($urandom_range(0, 3) == 0);
            bus.flush      = ($urandom_range(0, 149) == 0);
            bus.ALUControl = 3'($urandom_range(0, 7));
            bus.a          = rand_word();
            bus.b          = rand_word();
            tick();
        end
        bus.start = 1'b0; bus.flush = 1'b0;
        repeat (40) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
